// File: rtl/hamming_tx_scheduler.sv
// Two-requester round-robin front end sharing one Hamming(7,4) encoder; emits two codewords per byte.
// Latency: byte accepted at edge T -> first codeword valid in cycle T+1; one byte per 2 cycles sustained.
// Backpressure: code_ready=0 freezes the codeword and closes the accept window (no requester ready).
module hamming_tx_scheduler #(
  parameter int HI_FIRST = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  output logic             code_valid,
  output logic [6:0]       code_data,
  output logic             code_src,
  output logic             code_last,
  input  logic             code_ready,
  output logic             busy,
  output logic [CNT_W-1:0] cw_count
);

  typedef enum logic [1:0] {IDLE, NIB0, NIB1} state_t;

  state_t             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic               src_q, src_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_open;
  logic               any_valid;
  logic               winner;
  logic               accept;
  logic               handoff;
  logic [3:0]         first_nib, second_nib, cur_nib;
  logic [6:0]         enc;

  // Codeword layout {d3,d2,d1,d0,p1,p2,p3}
  function automatic logic [6:0] ham_enc(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p3 = d[2] ^ d[1] ^ d[0];
    return {d, p1, p2, p3};
  endfunction

  // Arbitration and accept window; window reopens in NIB1 only when the last nibble leaves
  always_comb begin
    win_open  = !rst && ((state_q == IDLE) || ((state_q == NIB1) && code_ready));
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) winner = ~last_grant_q;
    else                          winner = req1_valid;
    accept     = win_open & any_valid;
    req0_ready = accept & ~winner;
    req1_ready = accept &  winner;
  end

  // Nibble selection, encoding and output gating (outputs read as zero while idle)
  always_comb begin
    first_nib  = (HI_FIRST != 0) ? byte_q[7:4] : byte_q[3:0];
    second_nib = (HI_FIRST != 0) ? byte_q[3:0] : byte_q[7:4];
    cur_nib    = (state_q == NIB1) ? second_nib : first_nib;
    enc        = ham_enc(cur_nib);
    code_valid = (state_q != IDLE);
    code_data  = code_valid ? enc : 7'd0;
    code_src   = code_valid & src_q;
    code_last  = (state_q == NIB1);
    busy       = code_valid;
    cw_count   = cnt_q;
    handoff    = code_valid & code_ready;
  end

  // Next-state: byte register only loads on accept, so stalls never overwrite it
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q + CNT_W'(handoff);
    if (accept) begin
      byte_d       = winner ? req1_data : req0_data;
      src_d        = winner;
      last_grant_d = winner;
    end
    case (state_q)
      IDLE: if (accept) state_d = NIB0;
      NIB0: if (code_ready) state_d = NIB1;
      NIB1: if (code_ready) state_d = accept ? NIB0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; last_grant resets to 1 so req0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_q       <= 8'd0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Bench for hamming_tx_scheduler: a HI_FIRST=1/CNT_W=16 instance and a HI_FIRST=0/CNT_W=4 instance on shared inputs.
// Latency: checks are per cycle, sampled on the falling edge.
// Backpressure: exercised via code_ready stalls in the vector table.
module tb_hamming_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, code_ready = 1'b1;
  logic [7:0]  req0_data = 8'd0, req1_data = 8'd0;

  logic        r0, r1, cv, csrc, clast, bsy;
  logic [6:0]  cdat;
  logic [15:0] cnt;
  logic        b_r0, b_r1, b_cv, b_csrc, b_clast, b_bsy;
  logic [6:0]  b_cdat;
  logic [3:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_tx_scheduler #(.HI_FIRST(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1),
    .code_valid(cv), .code_data(cdat), .code_src(csrc), .code_last(clast),
    .code_ready(code_ready), .busy(bsy), .cw_count(cnt)
  );

  hamming_tx_scheduler #(.HI_FIRST(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1),
    .code_valid(b_cv), .code_data(b_cdat), .code_src(b_csrc), .code_last(b_clast),
    .code_ready(code_ready), .busy(b_bsy), .cw_count(b_cnt)
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       crdy;
    logic       ecv;
    logic [6:0] edat;
    logic [6:0] edat2;
    logic       esrc;
    logic       elast;
    logic       er0;
    logic       er1;
    int         ecnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic rs, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic cr,
                              input logic ecv, input logic [6:0] edat, input logic [6:0] edat2,
                              input logic esrc, input logic elast, input logic er0,
                              input logic er1, input int ecnt);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.crdy = cr;
    v.ecv = ecv; v.edat = edat; v.edat2 = edat2; v.esrc = esrc; v.elast = elast;
    v.er0 = er0; v.er1 = er1; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    int hs;
    int acc;

    // rst  v0  d0     v1  d1     cr | cv  dat    dat2   src last r0 r1 cnt
    tbl[0]  = mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 7'h00, 7'h00, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'hA5, 0, 8'h00, 1,  0, 7'h00, 7'h00, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 8'hA5, 0, 8'h00, 1,  1, 7'h55, 7'h2A, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 8'h00, 0, 8'h00, 1,  1, 7'h2A, 7'h55, 0, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 7'h00, 7'h00, 0, 0, 0, 0, 2);
    tbl[5]  = mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 7'h00, 7'h00, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 8'h3C, 1, 8'hFF, 1,  0, 7'h00, 7'h00, 0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 1, 8'h3C, 1, 8'hFF, 1,  1, 7'h1C, 7'h63, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 8'h3C, 1, 8'hFF, 1,  1, 7'h63, 7'h1C, 0, 1, 0, 1, 1);
    tbl[9]  = mk(0, 1, 8'h3C, 1, 8'hFF, 1,  1, 7'h7F, 7'h7F, 1, 0, 0, 0, 2);
    tbl[10] = mk(0, 1, 8'h3C, 1, 8'hFF, 1,  1, 7'h7F, 7'h7F, 1, 1, 1, 0, 3);
    tbl[11] = mk(0, 1, 8'h3C, 1, 8'hFF, 0,  1, 7'h1C, 7'h63, 0, 0, 0, 0, 4);
    tbl[12] = mk(0, 1, 8'h11, 1, 8'hFF, 0,  1, 7'h1C, 7'h63, 0, 0, 0, 0, 4);
    tbl[13] = mk(0, 1, 8'h11, 1, 8'hFF, 0,  1, 7'h1C, 7'h63, 0, 0, 0, 0, 4);
    tbl[14] = mk(0, 1, 8'h11, 1, 8'hFF, 0,  1, 7'h1C, 7'h63, 0, 0, 0, 0, 4);
    tbl[15] = mk(0, 1, 8'h11, 1, 8'hFF, 0,  1, 7'h1C, 7'h63, 0, 0, 0, 0, 4);
    tbl[16] = mk(0, 1, 8'h11, 1, 8'hFF, 1,  1, 7'h1C, 7'h63, 0, 0, 0, 0, 4);
    tbl[17] = mk(0, 0, 8'h00, 0, 8'h00, 1,  1, 7'h63, 7'h1C, 0, 1, 0, 0, 5);
    tbl[18] = mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 7'h00, 7'h00, 0, 0, 0, 0, 6);

    // Reset state
    #2;
    chk("rst_code_valid", int'(cv), 0);
    chk("rst_cw_count", int'(cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven cycles: single byte, tie alternation, backpressure
    for (int i = 0; i < 19; i++) begin
      rst        = tbl[i].rst;
      req0_valid = tbl[i].v0;
      req0_data  = tbl[i].d0;
      req1_valid = tbl[i].v1;
      req1_data  = tbl[i].d1;
      code_ready = tbl[i].crdy;
      @(negedge clk);
      chk($sformatf("v%0d_code_valid", i), int'(cv), int'(tbl[i].ecv));
      chk($sformatf("v%0d_busy", i), int'(bsy), int'(tbl[i].ecv));
      chk($sformatf("v%0d_code_data", i), int'(cdat), int'(tbl[i].edat));
      chk($sformatf("v%0d_lofirst_data", i), int'(b_cdat), int'(tbl[i].edat2));
      chk($sformatf("v%0d_code_src", i), int'(csrc), int'(tbl[i].esrc));
      chk($sformatf("v%0d_code_last", i), int'(clast), int'(tbl[i].elast));
      chk($sformatf("v%0d_req0_ready", i), int'(r0), int'(tbl[i].er0));
      chk($sformatf("v%0d_req1_ready", i), int'(r1), int'(tbl[i].er1));
      chk($sformatf("v%0d_cw_count", i), int'(cnt), tbl[i].ecnt);
      @(posedge clk); #1;
    end

    // Reset while the second nibble of 0xA5 is stalled
    req0_valid = 1'b1; req0_data = 8'hA5; req1_valid = 1'b0; code_ready = 1'b1;
    @(negedge clk);
    chk("mid_accept_r0", int'(r0), 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("mid_nib0_data", int'(cdat), 7'h55);
    @(posedge clk); #1;
    code_ready = 1'b0;
    @(negedge clk);
    chk("mid_nib1_data", int'(cdat), 7'h2A);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(cv), 0);
    chk("mid_rst_data", int'(cdat), 0);
    chk("mid_rst_last", int'(clast), 0);
    chk("mid_rst_busy", int'(bsy), 0);
    chk("mid_rst_count", int'(cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h3C; req1_valid = 1'b1; req1_data = 8'hFF; code_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_tie_r0", int'(r0), 1);
    chk("post_rst_tie_r1", int'(r1), 0);
    chk("post_rst_idle_valid", int'(cv), 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_first_cw", int'(cdat), 7'h1C);
    chk("post_rst_src", int'(csrc), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_second_cw", int'(cdat), 7'h63);
    @(posedge clk); #1;

    // Counter wrap on the 4-bit instance with eight 0x00 bytes back to back
    rst = 1'b1;
    #2 rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h00; code_ready = 1'b1;
    hs = 0; acc = 0;
    for (int c = 0; c < 60 && hs < 16; c++) begin
      @(negedge clk);
      if (r0 && req0_valid) acc++;
      if (cv) begin
        chk($sformatf("zero_cw%0d", hs), int'(cdat), 0);
        hs++;
      end
      @(posedge clk); #1;
      if (acc == 8) req0_valid = 1'b0;
    end
    chk("wrap_handshakes_seen", hs, 16);
    @(negedge clk);
    chk("wrap_cnt4", int'(b_cnt), 0);
    chk("wrap_cnt16", int'(cnt), 16);
    chk("wrap_idle", int'(cv), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
